// File: rtl/register_bank.sv
// register_bank
//   A bank of REG_COUNT registers, each DATA_WIDTH bits wide. It sits between
//   the control unit and the shared CPU data buses. It has one synchronous write
//   port, one in-place increment/decrement port that sets a registered wrap
//   flag (for PC/SP-style registers), and two independent tri-state read ports.
//
//   Optional build macro: REGISTER_BANK_BYPASS_EN
//     When defined, a write is forwarded to any enabled read port that selects
//     the write target, in the same cycle as the write. Step results are never
//     forwarded. When undefined, reads always show the stored contents.
//
//   Ports
//     clock, reset          rising-edge clock; synchronous active-high reset
//     load, load_sel,       write data_in into register load_sel
//       data_in
//     step_inc, step_dec,   +1 / -1 on register step_sel (both set = no step)
//       step_sel
//     oe_a, sel_a,          read port A; high-Z when oe_a=0
//       data_out_a
//     oe_b, sel_b,          read port B; high-Z when oe_b=0
//       data_out_b
//     wrap                  the last effective step wrapped around
module register_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_COUNT  = 8,
  parameter int SEL_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [SEL_WIDTH-1:0]  load_sel,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  step_inc,
  input  logic                  step_dec,
  input  logic [SEL_WIDTH-1:0]  step_sel,
  input  logic                  oe_a,
  input  logic [SEL_WIDTH-1:0]  sel_a,
  output logic [DATA_WIDTH-1:0] data_out_a,
  input  logic                  oe_b,
  input  logic [SEL_WIDTH-1:0]  sel_b,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  wrap
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic                  load_ok;
  logic                  step_ok;
  logic                  step_hit;
  logic                  step_wraps;
  logic [DATA_WIDTH-1:0] step_cur;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  // Select decode by matching against each implemented index. Out-of-range
  // selects match nothing, so they read as 0 and cannot write or step.
  always_comb begin
    load_ok  = 1'b0;
    step_ok  = 1'b0;
    step_cur = '0;
    rd_a     = '0;
    rd_b     = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (load_sel == SEL_WIDTH'(i)) load_ok = 1'b1;
      if (step_sel == SEL_WIDTH'(i)) begin
        step_ok  = 1'b1;
        step_cur = regs[i];
      end
      if (sel_a == SEL_WIDTH'(i)) rd_a = regs[i];
      if (sel_b == SEL_WIDTH'(i)) rd_b = regs[i];
    end
`ifdef REGISTER_BANK_BYPASS_EN
    if (load && load_ok && (sel_a == load_sel)) rd_a = data_in;
    if (load && load_ok && (sel_b == load_sel)) rd_b = data_in;
`endif
  end

  // A step is effective only when exactly one direction is requested, the
  // target exists, and a write to the same register does not take priority.
  assign step_hit   = (step_inc ^ step_dec) && step_ok &&
                      !(load && load_ok && (load_sel == step_sel));
  assign step_wraps = step_inc ? (&step_cur) : ~(|step_cur);

  assign data_out_a = oe_a ? rd_a : {DATA_WIDTH{1'bz}};
  assign data_out_b = oe_b ? rd_b : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      wrap <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (load && (load_sel == SEL_WIDTH'(i))) begin
          regs[i] <= data_in;
        end else if (step_hit && (step_sel == SEL_WIDTH'(i))) begin
          regs[i] <= step_inc ? regs[i] + DATA_WIDTH'(1)
                              : regs[i] - DATA_WIDTH'(1);
        end
      end
      if (step_hit) wrap <= step_wraps;
    end
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised successor to the single tri-state register: a bank of REG_COUNT general registers, each DATA_WIDTH bits wide, with one synchronous write port and two independent tri-state read ports (A and B) driving the CPU data buses.
- Adds in-place increment/decrement of one selected register per cycle, for PC/SP-style use, with a registered wrap flag.
- Sits between the control unit (selects, enables) and the shared buses.

Parameters:
- DATA_WIDTH, 16, bits per register and per bus.
- REG_COUNT, 8, number of registers; must be ≥2 and ≤2^SEL_WIDTH.
- SEL_WIDTH, 3, width of every select input.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  write data_in into register load_sel at the next rising edge.
- load_sel  input  SEL_WIDTH  write target.
- data_in  input  DATA_WIDTH  write data.
- step_inc  input  1  increment register step_sel by 1.
- step_dec  input  1  decrement register step_sel by 1.
- step_sel  input  SEL_WIDTH  increment/decrement target.
- oe_a  input  1  drive data_out_a.
- sel_a  input  SEL_WIDTH  read-A select.
- data_out_a  output  DATA_WIDTH  read port A, high-Z when oe_a=0.
- oe_b  input  1  drive data_out_b.
- sel_b  input  SEL_WIDTH  read-B select.
- data_out_b  output  DATA_WIDTH  read port B, high-Z when oe_b=0.
- wrap  output  1  registered flag: last step operation wrapped.

Behaviour:
- Reset is synchronous and active-high.
  - At a rising edge with reset=1: all registers go to 0 and wrap goes to 0.
  - reset overrides load and step_* in that cycle; any pending operation is dropped.
- Reads are combinational with 0-cycle latency.
  - data_out_x = reg[sel_x] when oe_x=1, else all bits Z.
  - oe is honoured during reset; outputs then show the pre-edge contents, and 0 after the edge.
  - Both ports may select the same register; both drive the same value.
- A select ≥ REG_COUNT:
  - Reads return 0.
  - Writes and steps to it are ignored, and wrap is not updated.
- Write: when load=1 at the edge, reg[load_sel] <= data_in. The new value is visible on the read ports after the edge (1-cycle write-to-read).
- Step, evaluated at the edge (arithmetic is modulo 2^DATA_WIDTH):
  - step_inc=1, step_dec=0: reg[step_sel] <= reg[step_sel]+1.
  - step_dec=1, step_inc=0: reg[step_sel] <= reg[step_sel]-1.
  - step_inc=1 and step_dec=1: no change to the register; treated as no step.
- wrap:
  - Updated only on an effective step (exactly one of inc/dec, valid select, not overridden by load).
  - Set to 1 for an inc from all-ones to 0, or a dec from 0 to all-ones; set to 0 for any other effective step.
  - Holds its value otherwise.
- Load and step in the same cycle:
  - Different targets: both occur.
  - Same target: load wins, the step is discarded, and wrap holds.
- Register updates use nonblocking assignment; no combinational path exists from data_in to the outputs (except under the optional feature).

Optional Feature:
- Macro: REGISTER_BANK_BYPASS_EN.
- Defined:
  - Write-through forwarding on both read ports. If load=1, load_sel is valid, and sel_x==load_sel, data_out_x (when oe_x=1) shows data_in in the same cycle.
  - Step results are not forwarded.
- Undefined: reads always show stored contents; 1-cycle write-to-read latency as above.

Test Plan:
- Reset then read: reset=1 for 1 edge, oe_a=1, sel_a=5 → data_out_a=0x0000 and wrap=0; oe_a=0 → data_out_a all Z.
- Write then dual read: load=1, load_sel=2, data_in=0xBEEF; next cycle sel_a=2, sel_b=2, both oe=1 → both ports 0xBEEF. With the bypass macro, 0xBEEF appears in the load cycle itself.
- Increment wrap: load reg3=0xFFFF, then step_inc=1, step_sel=3 → reg3=0x0000, wrap=1; a second inc → reg3=0x0001, wrap=0.
- Decrement wrap and inc+dec: reg4=0x0000, step_dec=1 → reg4=0xFFFF, wrap=1; then inc=dec=1 → reg4 stays 0xFFFF, wrap stays 1.
- Collision: reg1=0x0010, load=1, load_sel=1, data_in=0x1234 with step_inc=1, step_sel=1 → reg1=0x1234, wrap unchanged. Same with step_sel=6 (reg6=0x0007) → reg1=0x1234, reg6=0x0008.
- Reset mid-operation: load=1 to reg0=0xAAAA and step_inc on reg7 with reset=1 in the same cycle → reg0=0, reg7=0, wrap=0.
